mnist_image_loader: RTL and testbench
=====================================

// Module: mnist_image_loader
// PURPOSE
//   Writer side of the image buffer read by the inference datapath. Accepts an 8-bit grayscale
//   pixel stream, quantizes each pixel to int4 and writes it into an internal 784x4 RAM. Exposes a
//   1-cycle-latency read port with the same timing as the image ROM, pulses net_start, then returns
//   the network's predicted class to the host over a valid/ready result handshake.
// PARAMETERS
//   NUM_PIXELS  784  pixels per frame; address range 0..NUM_PIXELS-1
//   ADDR_W      10   read/write address width; requires 2**ADDR_W >= NUM_PIXELS
//   PIX_IN_W    8    input pixel width
//   PIX_Q_W     4    stored pixel width, int4 unsigned
// PORTS
//   clk        in   1        clock; all logic on the rising edge
//   rst        in   1        asynchronous, active-high reset
//   s_pixel    in   8        input pixel, unsigned 0..255
//   s_valid    in   1        s_pixel is valid
//   s_sof      in   1        start of frame, qualified by s_valid
//   s_ready    out  1        loader accepts a beat this cycle
//   rd_addr    in   10       network read address
//   rd_data    out  4        RAM[rd_addr], registered, 1-cycle latency
//   net_start  out  1        one-cycle pulse: frame complete, start inference
//   net_done   in   1        network done pulse
//   net_class  in   4        predicted class; sampled when net_done=1
//   res_class  out  4        held result class
//   res_valid  out  1        res_class is valid
//   res_ready  in   1        host takes the result
//   frame_err  out  1        one-cycle pulse on a framing error
//   busy       out  1        high in START, BUSY and RESULT
// BEHAVIOUR
//   - Reset values: s_ready=0, net_start=0, res_valid=0, res_class=0, frame_err=0, busy=0, state=IDLE.
//     s_ready rises in the first cycle after rst deasserts. RAM contents are not cleared.
//   - Accepted beat: s_valid && s_ready. s_ready=1 only in IDLE and LOAD.
//   - IDLE: a beat with s_sof writes addr 0, sets cnt=1 and moves to LOAD. A beat without s_sof is
//     discarded, pulses frame_err and stays in IDLE.
//   - LOAD: each beat writes q(s_pixel) to RAM[cnt] and increments cnt.
//   - LOAD, s_sof mid-frame: the beat is written at addr 0, cnt=1, frame_err pulses. The frame restarts.
//   - LOAD: the beat at cnt=NUM_PIXELS-1 is the last one; cnt wraps to 0 and the FSM goes to START.
//     s_ready is 0 in the following cycle.
//   - START: net_start=1 for exactly one cycle, then BUSY.
//     Latency: last beat accepted at edge N -> net_start high in cycle N+1.
//   - BUSY: wait for net_done. On net_done, register net_class into res_class, set res_valid=1 and go
//     to RESULT. A net_done seen outside BUSY is ignored.
//   - RESULT: hold res_valid and res_class stable until res_ready. On handshake, res_valid=0 in the
//     next cycle and the FSM returns to IDLE. res_ready while res_valid=0 has no effect.
//   - Read port: rd_data <= RAM[rd_addr] on every clock, in any state. When a read and a write hit
//     the same address in the same cycle, the read returns the old data.
//   - rst mid-frame or mid-inference: immediate return to IDLE with the reset values above. The
//     partial frame is abandoned and no net_start is issued.
//   - Quantization, default: q = s_pixel[7:4] (truncate).
// CONFIGURATION
//   PIXEL_ROUND_EN defined: q = min(15, (s_pixel + 8) >> 4), computed on 9 bits and saturated to 15.
//   PIXEL_ROUND_EN undefined: truncation. Timing and interface are identical in both builds.
// STRUCTURE
//   - Shared package mnist_pkg: NUM_PIXELS, ADDR_W, PIX_Q_W, and the loader state enum
//     {IDLE, LOAD, START, BUSY, RESULT}. Layer code uses the same constants.
//   - One sub-module, image_ram: NUM_PIXELS x PIX_Q_W simple dual-port RAM. One write port, one
//     synchronous read port, read-old-data on collision.
//   - FSM, pixel counter and quantizer stay in mnist_image_loader.
// TESTING
//   1. Full frame: 784 beats, pixel i = i%256, sof on beat 0 -> one net_start pulse one cycle after
//      the last beat. Read back addr 17 -> 1 (truncate build).
//   2. Quantization: 0x00->0, 0x18->1, 0xF8->15 (truncate build);
//      0x18->2, 0xF8->15 saturated, 0x07->0 (PIXEL_ROUND_EN build).
//   3. Resync: sof at beat 300, then 784 more beats -> frame_err pulses once, net_start only after
//      the second frame completes, addr 0 holds the pixel of the restart beat.
//   4. Result handshake: net_done with net_class=7, res_ready held low for 5 cycles -> res_class=7
//      stable and s_ready=0 throughout; res_ready=1 -> res_valid=0 in the next cycle, s_ready=1.
//   5. Backpressure/errors: s_valid without sof in IDLE -> frame_err pulse, nothing written;
//      s_valid during BUSY -> s_ready=0, no write.
//   6. Reset at beat 400 -> outputs at reset values, no net_start. A new full frame then completes
//      normally.

Source files
------------

// File: rtl/mnist_pkg.sv
// Shared constants and loader state encoding for the MNIST inference slice.
// Layer code imports the same frame geometry from here.
package mnist_pkg;

    localparam int NUM_PIXELS = 784;
    localparam int ADDR_W     = 10;
    localparam int PIX_IN_W   = 8;
    localparam int PIX_Q_W    = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        BUSY,
        RESULT
    } loader_state_t;

endpackage

// File: rtl/mnist_image_loader_if.sv
// Host-side bus of the image loader: the pixel stream into the loader and the
// result handshake back out. The host is master, the loader is slave.
interface mnist_image_loader_if;
    import mnist_pkg::*;

    logic [PIX_IN_W-1:0] s_pixel;
    logic                s_valid;
    logic                s_sof;
    logic                s_ready;
    logic [PIX_Q_W-1:0]  res_class;
    logic                res_valid;
    logic                res_ready;

    modport master (
        output s_pixel, s_valid, s_sof, res_ready,
        input  s_ready, res_class, res_valid
    );

    modport slave (
        input  s_pixel, s_valid, s_sof, res_ready,
        output s_ready, res_class, res_valid
    );

endinterface

// File: rtl/image_ram.sv
// NUM_PIXELS x PIX_Q_W simple dual-port image buffer. One write port and one
// registered read port; a same-address read and write returns the old word.
module image_ram
    import mnist_pkg::*;
(
    input  logic               clk,
    input  logic               we,
    input  logic [ADDR_W-1:0]  waddr,
    input  logic [PIX_Q_W-1:0] wdata,
    input  logic [ADDR_W-1:0]  raddr,
    output logic [PIX_Q_W-1:0] rdata
);

    logic [PIX_Q_W-1:0] mem [0:NUM_PIXELS-1];

    // Write and read share one edge; the read samples mem before the update lands.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/mnist_image_loader.sv
// Image loader: quantizes an 8-bit pixel stream into the image buffer, kicks
// the network once a full frame is stored and hands the predicted class back
// to the host. Build option PIXEL_ROUND_EN selects rounding instead of
// truncation in the quantizer; timing is identical either way.
//
// state  | meaning
// IDLE   | waiting for a start-of-frame beat
// LOAD   | storing pixels 1..NUM_PIXELS-1
// START  | one-cycle net_start pulse
// BUSY   | network running, waiting for net_done
// RESULT | res_valid held until the host takes the class
module mnist_image_loader
    import mnist_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    mnist_image_loader_if.slave  bus,
    input  logic [ADDR_W-1:0]    rd_addr,
    output logic [PIX_Q_W-1:0]   rd_data,
    output logic                 net_start,
    input  logic                 net_done,
    input  logic [PIX_Q_W-1:0]   net_class,
    output logic                 frame_err,
    output logic                 busy
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

    function automatic logic [PIX_Q_W-1:0] quantize(input logic [PIX_IN_W-1:0] p);
`ifdef PIXEL_ROUND_EN
        logic [PIX_IN_W:0] sum;
        sum = {1'b0, p} + (PIX_IN_W + 1)'(8);
        if (sum[PIX_IN_W]) begin
            return '1;
        end
        return sum[PIX_IN_W-1 -: PIX_Q_W];
`else
        return p[PIX_IN_W-1 -: PIX_Q_W];
`endif
    endfunction

    loader_state_t      state, state_d;
    logic [ADDR_W-1:0]  cnt, cnt_d;
    logic               s_ready_q, s_ready_d;
    logic               res_valid_q, res_valid_d;
    logic [PIX_Q_W-1:0] res_class_q, res_class_d;
    logic               frame_err_q, frame_err_d;
    logic               beat;
    logic               ram_we;
    logic [ADDR_W-1:0]  ram_waddr;

    assign beat = bus.s_valid && s_ready_q;

    // State, frame counter and registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            s_ready_q   <= 1'b0;
            res_valid_q <= 1'b0;
            res_class_q <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            s_ready_q   <= s_ready_d;
            res_valid_q <= res_valid_d;
            res_class_q <= res_class_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Next-state, counter, RAM write and result decisions.
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        res_valid_d = res_valid_q;
        res_class_d = res_class_q;
        frame_err_d = 1'b0;
        ram_we      = 1'b0;
        ram_waddr   = cnt;
        unique case (state)
            IDLE: begin
                if (beat) begin
                    if (bus.s_sof) begin
                        ram_we    = 1'b1;
                        ram_waddr = '0;
                        cnt_d     = ADDR_W'(1);
                        state_d   = LOAD;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (beat) begin
                    ram_we = 1'b1;
                    if (bus.s_sof) begin
                        // Restart: this beat becomes pixel 0 of a fresh frame.
                        ram_waddr   = '0;
                        cnt_d       = ADDR_W'(1);
                        frame_err_d = 1'b1;
                    end else if (cnt == LAST_ADDR) begin
                        cnt_d   = '0;
                        state_d = START;
                    end else begin
                        cnt_d = cnt + ADDR_W'(1);
                    end
                end
            end
            START: begin
                state_d = BUSY;
            end
            BUSY: begin
                if (net_done) begin
                    res_class_d = net_class;
                    res_valid_d = 1'b1;
                    state_d     = RESULT;
                end
            end
            RESULT: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        s_ready_d = (state_d == IDLE) || (state_d == LOAD);
    end

    assign bus.s_ready   = s_ready_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_class = res_class_q;
    assign frame_err     = frame_err_q;
    assign net_start     = (state == START);
    assign busy          = (state == START) || (state == BUSY) || (state == RESULT);

    image_ram u_image_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (quantize(bus.s_pixel)),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_mnist_image_loader.sv
// Self-checking bench for mnist_image_loader: a RAM model fed as beats are
// driven, a queue of expected read-back words, and per-scenario tasks.
module tb_mnist_image_loader;
    import mnist_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [9:0] rd_addr = '0;
    logic [3:0] rd_data;
    logic       net_start;
    logic       net_done = 1'b0;
    logic [3:0] net_class = '0;
    logic       frame_err;
    logic       busy;

    mnist_image_loader_if bus ();

    mnist_image_loader dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .net_start (net_start),
        .net_done  (net_done),
        .net_class (net_class),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int ns_cnt = 0;
    int fe_cnt = 0;
    int maddr = 0;
    int coll_addr = -1;

    logic [3:0] exp_mem [0:783];
    logic [7:0] pix_buf [0:2047];
    logic       sof_buf [0:2047];
    logic [3:0] exp_q [$];

    always @(negedge clk) begin
        if (net_start === 1'b1) ns_cnt++;
        if (frame_err === 1'b1) fe_cnt++;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog");
    end

    function automatic logic [3:0] qm(input logic [7:0] p);
`ifdef PIXEL_ROUND_EN
        int t;
        t = (int'(p) + 8) / 16;
        return (t > 15) ? 4'd15 : 4'(t);
`else
        return 4'(int'(p) / 16);
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fill_frame(input int kind);
        for (int i = 0; i < 784; i++) begin
            pix_buf[i] = (kind == 0) ? 8'(i % 256) : 8'((i * 7 + 3) % 256);
            sof_buf[i] = (i == 0);
        end
    endtask

    task automatic send_seq(input int n);
        logic [3:0] old;
        for (int i = 0; i < n; i++) begin
            bus.s_valid = 1'b1;
            bus.s_pixel = pix_buf[i];
            bus.s_sof   = sof_buf[i];
            chk("s_ready_beat", 32'(bus.s_ready), 32'd1);
            if (sof_buf[i]) maddr = 0;
            old = exp_mem[maddr];
            exp_mem[maddr] = qm(pix_buf[i]);
            tick();
            if (coll_addr == maddr) chk("collision_old_data", 32'(rd_data), 32'(old));
            maddr++;
        end
        bus.s_valid = 1'b0;
        bus.s_sof   = 1'b0;
    endtask

    task automatic read_addrs(input int a0, input int a1, input int a2, input int a3);
        int list [4];
        logic [3:0] e;
        list = '{a0, a1, a2, a3};
        foreach (list[k]) begin
            exp_q.push_back(exp_mem[list[k]]);
            rd_addr = 10'(list[k]);
            tick();
            e = exp_q.pop_front();
            chk($sformatf("rd_data[%0d]", list[k]), 32'(rd_data), 32'(e));
        end
    endtask

    task automatic check_frame_end(input int ns0);
        chk("net_start_latency", 32'(net_start), 32'd1);
        chk("s_ready_after_last", 32'(bus.s_ready), 32'd0);
        chk("net_start_early", 32'(ns_cnt - ns0), 32'd0);
        tick();
        chk("net_start_single", 32'(net_start), 32'd0);
        chk("busy_in_busy", 32'(busy), 32'd1);
        chk("net_start_count", 32'(ns_cnt - ns0), 32'd1);
    endtask

    task automatic finish_result(input logic [3:0] cls);
        net_class = cls;
        net_done  = 1'b1;
        tick();
        net_done  = 1'b0;
        chk("res_valid_set", 32'(bus.res_valid), 32'd1);
        chk("res_class_set", 32'(bus.res_class), 32'(cls));
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        chk("res_valid_clr", 32'(bus.res_valid), 32'd0);
        chk("s_ready_idle", 32'(bus.s_ready), 32'd1);
        chk("busy_idle", 32'(busy), 32'd0);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #3 rst = 1'b1;
        tick();
        tick();
        chk("rst_s_ready", 32'(bus.s_ready), 32'd0);
        chk("rst_net_start", 32'(net_start), 32'd0);
        chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
        chk("rst_res_class", 32'(bus.res_class), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick();
        chk("s_ready_after_rst", 32'(bus.s_ready), 32'd1);
    endtask

    task automatic test_full_frame();
        int ns0;
        ns0 = ns_cnt;
        fill_frame(0);
        send_seq(784);
        check_frame_end(ns0);
        finish_result(4'd3);
        read_addrs(17, 0, 255, 783);
    endtask

    task automatic test_quant();
        int ns0;
        ns0 = ns_cnt;
        fill_frame(0);
        pix_buf[1] = 8'h00;
        pix_buf[2] = 8'h18;
        pix_buf[3] = 8'hF8;
        pix_buf[4] = 8'h07;
        coll_addr = 2;
        rd_addr = 10'd2;
        send_seq(784);
        coll_addr = -1;
        check_frame_end(ns0);
        finish_result(4'd9);
        read_addrs(1, 2, 3, 4);
    endtask

    task automatic test_result();
        int ns0;
        ns0 = ns_cnt;
        fill_frame(1);
        send_seq(784);
        check_frame_end(ns0);
        repeat (3) begin
            tick();
            chk("res_valid_wait", 32'(bus.res_valid), 32'd0);
        end
        net_class = 4'd7;
        net_done  = 1'b1;
        tick();
        net_done  = 1'b0;
        net_class = 4'd2;
        for (int c = 0; c < 5; c++) begin
            chk("hold_res_valid", 32'(bus.res_valid), 32'd1);
            chk("hold_res_class", 32'(bus.res_class), 32'd7);
            chk("hold_s_ready", 32'(bus.s_ready), 32'd0);
            tick();
        end
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        chk("hs_res_valid", 32'(bus.res_valid), 32'd0);
        chk("hs_s_ready", 32'(bus.s_ready), 32'd1);
        chk("hs_res_class_held", 32'(bus.res_class), 32'd7);
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        chk("idle_res_ready_noop", 32'(bus.res_valid), 32'd0);
    endtask

    task automatic test_resync();
        int ns0, fe0;
        ns0 = ns_cnt;
        fe0 = fe_cnt;
        for (int i = 0; i < 1084; i++) begin
            if (i < 300) pix_buf[i] = 8'(i % 256);
            else if (i == 300) pix_buf[i] = 8'hA0;
            else pix_buf[i] = 8'((i * 3) % 256);
            sof_buf[i] = (i == 0) || (i == 300);
        end
        send_seq(1084);
        check_frame_end(ns0);
        chk("resync_frame_err_once", 32'(fe_cnt - fe0), 32'd1);
        finish_result(4'd5);
        read_addrs(0, 1, 299, 783);
    endtask

    task automatic test_errors();
        int fe0;
        int ns0;
        fe0 = fe_cnt;
        net_done = 1'b1;
        net_class = 4'd11;
        tick();
        net_done = 1'b0;
        chk("idle_net_done_ignored", 32'(bus.res_valid), 32'd0);
        bus.s_valid = 1'b1;
        bus.s_sof   = 1'b0;
        bus.s_pixel = 8'hFF;
        tick();
        bus.s_valid = 1'b0;
        tick();
        chk("nosof_frame_err", 32'(fe_cnt - fe0), 32'd1);
        chk("nosof_stay_idle", 32'(bus.s_ready), 32'd1);
        read_addrs(0, 1, 2, 3);
        ns0 = ns_cnt;
        fill_frame(0);
        send_seq(784);
        check_frame_end(ns0);
        bus.s_valid = 1'b1;
        bus.s_sof   = 1'b1;
        bus.s_pixel = 8'h55;
        repeat (3) begin
            chk("busy_s_ready", 32'(bus.s_ready), 32'd0);
            tick();
            chk("busy_held", 32'(busy), 32'd1);
        end
        bus.s_valid = 1'b0;
        bus.s_sof   = 1'b0;
        finish_result(4'd1);
        read_addrs(0, 5, 100, 783);
    endtask

    task automatic test_reset_mid();
        int ns0;
        ns0 = ns_cnt;
        for (int i = 0; i < 400; i++) begin
            pix_buf[i] = 8'(255 - (i % 256));
            sof_buf[i] = (i == 0);
        end
        send_seq(400);
        rst = 1'b1;
        #1;
        chk("midrst_s_ready", 32'(bus.s_ready), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_net_start", 32'(net_start), 32'd0);
        chk("midrst_res_valid", 32'(bus.res_valid), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("midrst_s_ready_back", 32'(bus.s_ready), 32'd1);
        repeat (3) tick();
        chk("midrst_no_net_start", 32'(ns_cnt - ns0), 32'd0);
        ns0 = ns_cnt;
        fill_frame(1);
        send_seq(784);
        check_frame_end(ns0);
        finish_result(4'd12);
        read_addrs(0, 399, 400, 783);
    endtask

    initial begin
        bus.s_valid   = 1'b0;
        bus.s_sof     = 1'b0;
        bus.s_pixel   = '0;
        bus.res_ready = 1'b0;
        test_reset();
        test_full_frame();
        test_quant();
        test_result();
        test_resync();
        test_errors();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
